sprite_move_engine: RTL and testbench



---
 rtl/sprite_move_engine.sv | 186 ++++++++++++++++++
 tb/tb_sprite_move_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_engine.sv
// Per-frame sprite movement sequencer: walks the sprite table, advances moving
// sprites with clamp/wrap/bounce edge handling, writes them back, hands each active sprite to the drawer.
module sprite_move_engine #(
    parameter int NUM_SPRITES      = 8,
    parameter int IDX_W            = 3,
    parameter int ADDR_W           = 24,
    parameter int BASE_ADDR        = 0,
    parameter int WORDS_PER_SPRITE = 2,
    parameter int X_W              = 10,
    parameter int Y_W              = 9,
    parameter int X_MAX            = 639,
    parameter int Y_MAX            = 479,
    parameter int EDGE_MODE        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       mem_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              draw_rdy,
    output logic              draw_start,
    output logic [IDX_W-1:0]  draw_idx,
    output logic [X_W-1:0]    draw_x,
    output logic [Y_W-1:0]    draw_y,
    output logic [7:0]        draw_image,
    output logic              busy,
    output logic              done
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_FLAGS, S_WAIT_FLAGS, S_RD_COORD, S_WAIT_COORD,
        S_UPDATE, S_WR_COORD, S_WR_FLAGS, S_DRAW_REQ, S_NEXT
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        flags;
    logic [X_W-1:0]     pos_x, x_calc;
    logic [Y_W-1:0]     pos_y, y_calc;
    logic [1:0]         dir_calc;
    logic               dir_chg;
    logic [ADDR_W-1:0]  rec;
    logic               last;
    logic [XW1-1:0]     xe, spx, x_sum;
    logic [YW1-1:0]     ye, spy, y_sum;

    assign rec   = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(WORDS_PER_SPRITE);
    assign last  = (idx == IDX_W'(NUM_SPRITES - 1));
    assign xe    = XW1'(pos_x);
    assign ye    = YW1'(pos_y);
    assign spx   = XW1'(flags[27:20]);
    assign spy   = YW1'(flags[27:20]);
    assign x_sum = xe + spx;
    assign y_sum = ye + spy;

    // Wrap on the low edge adds the full span first so the subtraction never underflows.
    always_comb begin
        x_calc   = pos_x;
        y_calc   = pos_y;
        dir_calc = flags[29:28];
        case (flags[29:28])
            2'b00: begin
                if (spy <= ye)          y_calc = Y_W'(ye - spy);
                else if (EDGE_MODE == 1) y_calc = Y_W'(ye + YW1'(Y_MAX + 1) - spy);
                else begin
                    y_calc = '0;
                    if (EDGE_MODE == 2) dir_calc = 2'b01;
                end
            end
            2'b01: begin
                if (y_sum <= YW1'(Y_MAX)) y_calc = Y_W'(y_sum);
                else if (EDGE_MODE == 1)  y_calc = Y_W'(y_sum - YW1'(Y_MAX + 1));
                else begin
                    y_calc = Y_W'(Y_MAX);
                    if (EDGE_MODE == 2) dir_calc = 2'b00;
                end
            end
            2'b10: begin
                if (spx <= xe)          x_calc = X_W'(xe - spx);
                else if (EDGE_MODE == 1) x_calc = X_W'(xe + XW1'(X_MAX + 1) - spx);
                else begin
                    x_calc = '0;
                    if (EDGE_MODE == 2) dir_calc = 2'b11;
                end
            end
            default: begin
                if (x_sum <= XW1'(X_MAX)) x_calc = X_W'(x_sum);
                else if (EDGE_MODE == 1)  x_calc = X_W'(x_sum - XW1'(X_MAX + 1));
                else begin
                    x_calc = X_W'(X_MAX);
                    if (EDGE_MODE == 2) dir_calc = 2'b10;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            flags   <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
            dir_chg <= 1'b0;
        end else begin
            case (state)
                S_WAIT_FLAGS: flags <= mem_rdata;
                S_WAIT_COORD: begin
                    pos_x <= mem_rdata[X_W-1:0];
                    pos_y <= mem_rdata[X_W +: Y_W];
                end
                S_UPDATE: begin
                    pos_x          <= x_calc;
                    pos_y          <= y_calc;
                    flags[29:28]   <= dir_calc;
                    dir_chg        <= (dir_calc != flags[29:28]);
                end
                S_NEXT: idx <= last ? '0 : idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Strobes, address and write data are decoded from state so reset kills them at once.
    always_comb begin
        state_nxt  = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        draw_start = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:       if (start) state_nxt = S_RD_FLAGS;
            S_RD_FLAGS: begin
                mem_re    = 1'b1;
                mem_addr  = rec;
                state_nxt = S_WAIT_FLAGS;
            end
            S_WAIT_FLAGS: state_nxt = mem_rdata[31] ? S_RD_COORD : S_NEXT;
            S_RD_COORD: begin
                mem_re    = 1'b1;
                mem_addr  = rec + ADDR_W'(1);
                state_nxt = S_WAIT_COORD;
            end
            S_WAIT_COORD: state_nxt = flags[30] ? S_UPDATE : S_DRAW_REQ;
            S_UPDATE:     state_nxt = S_WR_COORD;
            S_WR_COORD: begin
                mem_we    = 1'b1;
                mem_addr  = rec + ADDR_W'(1);
                mem_wdata = 32'({pos_y, pos_x});
                state_nxt = dir_chg ? S_WR_FLAGS : S_DRAW_REQ;
            end
            S_WR_FLAGS: begin
                mem_we    = 1'b1;
                mem_addr  = rec;
                mem_wdata = flags;
                state_nxt = S_DRAW_REQ;
            end
            S_DRAW_REQ: if (draw_rdy) begin
                draw_start = 1'b1;
                state_nxt  = S_NEXT;
            end
            S_NEXT: begin
                done      = last;
                state_nxt = last ? S_IDLE : S_RD_FLAGS;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign draw_idx   = idx;
    assign draw_x     = pos_x;
    assign draw_y     = pos_y;
    assign draw_image = flags[7:0];
endmodule

// File: tb/tb_sprite_move_engine.sv
// Bench for sprite_move_engine: three instances (clamp, wrap, bounce) of a 4-sprite engine,
// each with its own sprite memory, checked against a plain-arithmetic movement model.
module tb_sprite_move_engine;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rdy_mode = 2'd0;
    logic       rdy_man = 1'b0;
    logic       rdy_rnd = 1'b1;
    logic       draw_rdy;
    always @(posedge clk) rdy_rnd <= 1'($urandom_range(0, 1));
    assign draw_rdy = (rdy_mode == 2'd0) ? 1'b1 : (rdy_mode == 2'd1) ? rdy_rnd : rdy_man;

    logic        mem_re[3], mem_we[3], draw_start[3], busy[3], done[3];
    logic [23:0] mem_addr[3];
    logic [31:0] mem_wdata[3], mem_rdata[3];
    logic [1:0]  draw_idx[3];
    logic [9:0]  draw_x[3];
    logic [8:0]  draw_y[3];
    logic [7:0]  draw_image[3];

    for (genvar g = 0; g < 3; g++) begin : u
        sprite_move_engine #(.NUM_SPRITES(NS), .IDX_W(2), .EDGE_MODE(g)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata[g]),
            .mem_re(mem_re[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .draw_rdy(draw_rdy), .draw_start(draw_start[g]),
            .draw_idx(draw_idx[g]), .draw_x(draw_x[g]), .draw_y(draw_y[g]),
            .draw_image(draw_image[g]), .busy(busy[g]), .done(done[g])
        );
    end

    logic [31:0] mem[3][8], init_mem[3][8], gmem[3][8];
    logic        ld = 1'b0;
    always @(posedge clk) begin
        if (ld) mem <= init_mem;
        for (int g = 0; g < 3; g++) begin
            if (!ld && mem_we[g]) mem[g][mem_addr[g][2:0]] <= mem_wdata[g];
            mem_rdata[g] <= mem_re[g] ? mem[g][mem_addr[g][2:0]] : 32'hDEAD_BEEF;
        end
    end

    // Event log sampled mid-cycle; records packed as {idx, y, x, image}.
    int          wr_cnt[3] = '{0, 0, 0}, dr_cnt[3] = '{0, 0, 0}, done_cnt[3] = '{0, 0, 0};
    int          act_cnt[3] = '{0, 0, 0}, excl_cnt[3] = '{0, 0, 0};
    logic [31:0] wr_a[3][256], wr_d[3][256], dr_rec[3][256];
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mem_we[g]) begin
                wr_a[g][wr_cnt[g][7:0]] <= 32'(mem_addr[g]);
                wr_d[g][wr_cnt[g][7:0]] <= mem_wdata[g];
                wr_cnt[g] <= wr_cnt[g] + 1;
            end
            if (draw_start[g]) begin
                dr_rec[g][dr_cnt[g][7:0]] <= {3'b0, draw_idx[g], draw_y[g], draw_x[g], draw_image[g]};
                dr_cnt[g] <= dr_cnt[g] + 1;
            end
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
            if (mem_re[g] || mem_we[g] || draw_start[g]) act_cnt[g] <= act_cnt[g] + 1;
            if ((mem_re[g] && mem_we[g]) || (!mem_we[g] && mem_wdata[g] != 32'h0))
                excl_cnt[g] <= excl_cnt[g] + 1;
        end
    end

    int ntests = 0, nfail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Movement model: step by speed, then resolve an off-screen result by edge mode.
    function automatic void mv(input int mode, input int x, input int y, input int d, input int s,
                               output int nx, output int ny, output int nd);
        nx = x; ny = y; nd = d;
        case (d)
            0: begin ny = y - s; if (ny < 0) begin
                   if (mode == 1) ny = ny + 480; else ny = 0;
                   if (mode == 2) nd = 1;
               end end
            1: begin ny = y + s; if (ny > 479) begin
                   if (mode == 1) ny = ny - 480; else ny = 479;
                   if (mode == 2) nd = 0;
               end end
            2: begin nx = x - s; if (nx < 0) begin
                   if (mode == 1) nx = nx + 640; else nx = 0;
                   if (mode == 2) nd = 3;
               end end
            default: begin nx = x + s; if (nx > 639) begin
                   if (mode == 1) nx = nx - 640; else nx = 639;
                   if (mode == 2) nd = 2;
               end end
        endcase
    endfunction

    task automatic load_mem();
        init_mem = gmem;
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    function automatic int act_sum();
        return act_cnt[0] + act_cnt[1] + act_cnt[2];
    endfunction

    task automatic wait_done(input int dnb[3]);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_cnt[0] > dnb[0] && done_cnt[1] > dnb[1] && done_cnt[2] > dnb[2]) break;
        end
    endtask

    task automatic run_pass(input bit mid_start);
        logic [31:0] emem[3][8];
        logic [31:0] ewa[3][16], ewd[3][16], edr[3][4], f, cw;
        int ewn[3], edn[3], wb[3], db[3], dnb[3], exb[3];
        int x, y, d, nx, ny, nd, n;
        emem = gmem;
        for (int g = 0; g < 3; g++) begin
            ewn[g] = 0; edn[g] = 0;
            for (int i = 0; i < NS; i++) begin
                f = gmem[g][2*i];
                if (f[31]) begin
                    cw = gmem[g][2*i+1];
                    x = int'(cw[9:0]); y = int'(cw[18:10]); d = int'(f[29:28]);
                    nx = x; ny = y; nd = d;
                    if (f[30]) begin
                        mv(g, x, y, d, int'(f[27:20]), nx, ny, nd);
                        cw = {13'b0, 9'(ny), 10'(nx)};
                        emem[g][2*i+1] = cw;
                        ewa[g][ewn[g]] = 32'(2*i+1); ewd[g][ewn[g]] = cw; ewn[g]++;
                        if (nd != d) begin
                            f[29:28] = 2'(nd);
                            emem[g][2*i] = f;
                            ewa[g][ewn[g]] = 32'(2*i); ewd[g][ewn[g]] = f; ewn[g]++;
                        end
                    end
                    edr[g][edn[g]] = {3'b0, 2'(i), 9'(ny), 10'(nx), f[7:0]};
                    edn[g]++;
                end
            end
        end
        load_mem();
        for (int g = 0; g < 3; g++) begin
            wb[g] = wr_cnt[g]; db[g] = dr_cnt[g]; dnb[g] = done_cnt[g]; exb[g] = excl_cnt[g];
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (mid_start) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
        end
        wait_done(dnb);
        repeat (4) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("done pulses m%0d", g), 32'(done_cnt[g] - dnb[g]), 32'd1);
            chk($sformatf("busy after m%0d", g), 32'(busy[g]), 32'd0);
            n = wr_cnt[g] - wb[g];
            chk($sformatf("write count m%0d", g), 32'(n), 32'(ewn[g]));
            for (int k = 0; k < ewn[g] && k < n; k++) begin
                chk($sformatf("write addr m%0d #%0d", g, k), wr_a[g][8'(wb[g] + k)], ewa[g][k]);
                chk($sformatf("write data m%0d #%0d", g, k), wr_d[g][8'(wb[g] + k)], ewd[g][k]);
            end
            n = dr_cnt[g] - db[g];
            chk($sformatf("draw count m%0d", g), 32'(n), 32'(edn[g]));
            for (int k = 0; k < edn[g] && k < n; k++)
                chk($sformatf("draw rec m%0d #%0d", g, k), dr_rec[g][8'(db[g] + k)], edr[g][k]);
            for (int a = 0; a < 8; a++)
                chk($sformatf("mem m%0d [%0d]", g, a), mem[g][a], emem[g][a]);
            chk($sformatf("strobe rules m%0d", g), 32'(excl_cnt[g] - exb[g]), 32'd0);
        end
        gmem = emem;
    endtask

    typedef struct { int mode, x, y, dir, spd, ex, ey, ed; } vec_t;
    vec_t vt[12];

    initial begin
        int a0, k, dnb[3];
        logic [31:0] f0, c0;
        bit seen;
        vt[0]  = '{0, 630, 100, 3, 20, 639, 100, 3};
        vt[1]  = '{1,  50,   3, 0,  8,  50, 475, 0};
        vt[2]  = '{2,  50,   3, 0,  8,  50,   0, 1};
        vt[3]  = '{2, 630, 100, 3,  9, 639, 100, 3};
        vt[4]  = '{2,   5, 100, 2, 10,   0, 100, 3};
        vt[5]  = '{1, 635, 100, 3, 10,   5, 100, 3};
        vt[6]  = '{0, 200, 470, 1, 20, 200, 479, 1};
        vt[7]  = '{1, 200, 470, 1, 20, 200,  10, 1};
        vt[8]  = '{2, 200, 470, 1, 20, 200, 479, 0};
        vt[9]  = '{0, 100, 100, 2,  0, 100, 100, 2};
        vt[10] = '{1,   0, 100, 2,  1, 639, 100, 2};
        vt[11] = '{2, 300,   8, 0,  8, 300,   0, 0};
        for (int g = 0; g < 3; g++) for (int w = 0; w < 8; w++) gmem[g][w] = 32'h0;

        // Reset held with start high: everything quiet.
        start = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset ctrl m%0d", g),
                32'({busy[g], done[g], mem_re[g], mem_we[g], draw_start[g]}), 32'd0);
            chk($sformatf("reset addr/data m%0d", g), 32'(mem_addr[g]) | mem_wdata[g], 32'd0);
            chk($sformatf("reset draw m%0d", g),
                {3'b0, draw_idx[g], draw_y[g], draw_x[g], draw_image[g]}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        a0 = act_sum();
        repeat (3) @(negedge clk);
        chk("idle after reset busy", 32'(busy[0] | busy[1] | busy[2]), 32'd0);
        chk("idle after reset activity", 32'(act_sum() - a0), 32'd0);
        run_pass(1'b0);

        // Table vectors: one moving sprite in the instance of the given edge mode.
        for (int v = 0; v < 12; v++) begin
            for (int g = 0; g < 3; g++) for (int w = 0; w < 8; w++) gmem[g][w] = 32'h0;
            f0 = {2'b11, 2'(vt[v].dir), 8'(vt[v].spd), 12'hABC, 8'h5A};
            gmem[vt[v].mode][0] = f0;
            gmem[vt[v].mode][1] = {13'h1234, 9'(vt[v].y), 10'(vt[v].x)};
            run_pass(1'b0);
            chk($sformatf("vec%0d x", v), 32'(mem[vt[v].mode][1][9:0]), 32'(vt[v].ex));
            chk($sformatf("vec%0d y", v), 32'(mem[vt[v].mode][1][18:10]), 32'(vt[v].ey));
            chk($sformatf("vec%0d dir", v), 32'(mem[vt[v].mode][0][29:28]), 32'(vt[v].ed));
            chk($sformatf("vec%0d other flags", v),
                {2'b0, mem[vt[v].mode][0][31:30], mem[vt[v].mode][0][27:0]},
                {2'b0, f0[31:30], f0[27:0]});
            k = dr_cnt[vt[v].mode] - 1;
            chk($sformatf("vec%0d draw xy", v), 32'(dr_rec[vt[v].mode][k[7:0]][26:8]),
                32'({9'(vt[v].ey), 10'(vt[v].ex)}));
        end

        // Sprites 1 and 3 inactive: two draws, no writes to their records.
        for (int g = 0; g < 3; g++) begin
            gmem[g][0] = 32'hD012_3401; gmem[g][1] = {13'h0, 9'd50, 10'd60};
            gmem[g][2] = 32'h7FFF_FFFF; gmem[g][3] = 32'h0000_1234;
            gmem[g][4] = 32'hC0F0_0002; gmem[g][5] = {13'h0, 9'd400, 10'd600};
            gmem[g][6] = 32'h4000_0003; gmem[g][7] = 32'h0000_0000;
        end
        run_pass(1'b1);

        // Drawer stall: sprite 0 parked in the draw request for 10 cycles.
        for (int g = 0; g < 3; g++) begin
            for (int w = 0; w < 8; w++) gmem[g][w] = 32'h0;
            gmem[g][0] = 32'h8000_0077; gmem[g][1] = {13'h0, 9'd33, 10'd44};
        end
        load_mem();
        rdy_mode = 2'd2; rdy_man = 1'b0;
        for (int g = 0; g < 3; g++) dnb[g] = done_cnt[g];
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (8) @(negedge clk);
        a0 = act_sum();
        repeat (10) @(negedge clk);
        chk("stall activity", 32'(act_sum() - a0), 32'd0);
        chk("stall busy", 32'(busy[0]), 32'd1);
        @(posedge clk) #1 rdy_man = 1'b1;
        @(negedge clk);
        chk("stall release pulse", 32'(draw_start[0]), 32'd1);
        chk("stall release draw", {draw_idx[0], draw_y[0], draw_x[0], draw_image[0]},
            {2'd0, 9'd33, 10'd44, 8'h77});
        @(negedge clk);
        chk("stall single pulse", 32'(draw_start[0]), 32'd0);
        wait_done(dnb);
        chk("stall done", 32'(done_cnt[0] - dnb[0]), 32'd1);
        rdy_mode = 2'd0;

        // Reset asserted while the coordinate write strobe is up.
        for (int g = 0; g < 3; g++) begin
            gmem[g][0] = 32'hF050_0000; gmem[g][1] = {13'h0, 9'd20, 10'd10};
        end
        load_mem();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (mem_we[0]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reach write strobe", 32'(seen), 32'd1);
        c0 = mem[0][1];
        #1 rst_n = 1'b0;
        #1 chk("write drops on reset", 32'(mem_we[0]), 32'd0);
        a0 = act_sum();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no strobes after reset", 32'(act_sum() - a0), 32'd0);
        chk("write not committed", mem[0][1], c0);
        chk("idle after mid reset", 32'(busy[0]), 32'd0);

        // Randomized tables, with random drawer backpressure and stray starts.
        for (int p = 0; p < 15; p++) begin
            for (int g = 0; g < 3; g++) for (int i = 0; i < NS; i++) begin
                gmem[g][2*i] = $urandom;
                c0 = $urandom;
                c0[18:0] = {9'($urandom_range(0, 479)), 10'($urandom_range(0, 639))};
                gmem[g][2*i+1] = c0;
            end
            rdy_mode = (p % 2 == 1) ? 2'd1 : 2'd0;
            run_pass(p % 3 == 0);
        end
        rdy_mode = 2'd0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
